// File: rtl/usbf_ahb_mst.sv
// AHB-Lite master engine for the USB device controller: moves payload between
// the endpoint buffers and system memory as word-sized INCR bursts.
module usbf_ahb_mst #(
  parameter int LEN_W = 10
) (
  input  logic             hclk_i,
  input  logic             hrstn_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [31:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [31:0]      wdata_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  output logic [31:0]      rdata_o,
  output logic             rdata_valid_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      haddr_o,
  output logic [1:0]       htrans_o,
  output logic             hwrite_o,
  output logic [2:0]       hsize_o,
  output logic [2:0]       hburst_o,
  output logic [31:0]      hwdata_o,
  input  logic             hready_i,
  input  logic [1:0]       hresp_i,
  input  logic [31:0]      hrdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_LAST, S_ERR} state_t;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_NSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  state_t             state_q, state_d;
  logic               dir_q;
  logic [31:0]        addr_q;      // address of the next beat to issue
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issue_cnt;
  logic [LEN_W-1:0]   done_cnt;
  logic               dph_q;       // a data phase is outstanding on the bus
  logic               done_d, err_d;

  logic cmd_acc, bus_err, addr_acc, data_done, last_issue, last_done;

  assign hsize_o     = 3'b010;
  assign hburst_o    = 3'b001;
  assign haddr_o     = addr_q;
  assign hwrite_o    = dir_q;
  assign cmd_ready_o = (state_q == S_IDLE);

  assign cmd_acc       = cmd_valid_i & cmd_ready_o;
  assign bus_err       = dph_q & (hresp_i == 2'b01) & ~hready_i;
  assign addr_acc      = hready_i & htrans_o[1];
  assign data_done     = dph_q & hready_i & (hresp_i == 2'b00);
  assign wdata_ready_o = addr_acc & dir_q;
  assign last_issue    = (issue_cnt + LEN_W'(1)) == len_q;
  assign last_done     = (done_cnt + LEN_W'(1)) == len_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    htrans_o = TR_IDLE;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          if (cmd_len_i == '0) done_d = 1'b1;
          else                 state_d = S_XFER;
        end
      end
      S_XFER: begin
        // The first ERROR cycle cancels whatever address would have been offered.
        if (bus_err) begin
          state_d = S_ERR;
        end else begin
          if (dir_q && !wdata_valid_i)
            htrans_o = (issue_cnt == '0) ? TR_IDLE : TR_BUSY;
          else if (issue_cnt == '0 || addr_q[9:2] == 8'h00)
            htrans_o = TR_NSEQ;
          else
            htrans_o = TR_SEQ;
          if (hready_i && htrans_o[1] && last_issue) state_d = S_LAST;
        end
      end
      S_LAST: begin
        if (bus_err) begin
          state_d = S_ERR;
        end else if (data_done && last_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_ERR: begin
        if (hready_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk_i or negedge hrstn_i) begin
    if (!hrstn_i) begin
      state_q       <= S_IDLE;
      dir_q         <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      issue_cnt     <= '0;
      done_cnt      <= '0;
      dph_q         <= 1'b0;
      hwdata_o      <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_o        <= done_d;
      err_o         <= err_d;
      rdata_valid_o <= data_done & ~dir_q;
      if (data_done && !dir_q) rdata_o <= hrdata_i;
      if (hready_i) dph_q <= addr_acc;
      if (wdata_ready_o) hwdata_o <= wdata_i;
      if (cmd_acc && cmd_len_i != '0) begin
        dir_q     <= cmd_write_i;
        addr_q    <= {cmd_addr_i[31:2], 2'b00};
        len_q     <= cmd_len_i;
        issue_cnt <= '0;
        done_cnt  <= '0;
      end else begin
        if (addr_acc) begin
          addr_q    <= addr_q + 32'd4;
          issue_cnt <= issue_cnt + LEN_W'(1);
        end
        if (data_done) done_cnt <= done_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_usbf_ahb_mst.sv
// Directed bench for usbf_ahb_mst: a scripted AHB slave drives each cycle and
// every DUT output is compared against hand-derived values.
module tb_usbf_ahb_mst;

  localparam int LEN_W = 10;
  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [1:0] OK = 2'b00, ER = 2'b01;
  localparam logic [31:0] G = 32'hBAD0_BAD0;

  logic             hclk_i = 1'b0;
  logic             hrstn_i;
  logic             cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0]      cmd_addr_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic [31:0]      wdata_i;
  logic             wdata_valid_i, wdata_ready_o;
  logic [31:0]      rdata_o;
  logic             rdata_valid_o, done_o, err_o;
  logic [31:0]      haddr_o;
  logic [1:0]       htrans_o;
  logic             hwrite_o;
  logic [2:0]       hsize_o, hburst_o;
  logic [31:0]      hwdata_o;
  logic             hready_i;
  logic [1:0]       hresp_i;
  logic [31:0]      hrdata_i;

  int    n_checks = 0;
  int    n_errors = 0;
  string tname;
  int    cyc_no;

  usbf_ahb_mst #(.LEN_W(LEN_W)) dut (
    .hclk_i(hclk_i), .hrstn_i(hrstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .err_o(err_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
    .hburst_o(hburst_o), .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i),
    .hrdata_i(hrdata_i)
  );

  always #5 hclk_i = ~hclk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk_i);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [LEN_W-1:0] len);
    hready_i = 1'b1; hresp_i = OK; wdata_valid_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = len;
    #1;
    check({tname, " cmd_ready"}, cmd_ready_o, 1);
    tick();
    // Scramble the command fields so a design that fails to latch them shows it.
    cmd_valid_i = 1'b0; cmd_write_i = ~wr; cmd_addr_i = '1; cmd_len_i = '1;
    cyc_no = 1;
  endtask

  // One bus cycle: drive slave/source inputs, then compare outputs mid-cycle.
  task automatic cyc(input logic rdy, input logic [1:0] resp, input logic [31:0] rd,
                     input logic wv, input logic [31:0] wd,
                     input logic [1:0] e_tr, input logic [31:0] e_addr, input logic e_wrdy,
                     input logic c_wd, input logic [31:0] e_wd,
                     input logic e_rv, input logic [31:0] e_rdata,
                     input logic e_done, input logic e_err);
    string pfx;
    hready_i = rdy; hresp_i = resp; hrdata_i = rd; wdata_valid_i = wv; wdata_i = wd;
    #1;
    pfx = $sformatf("%s c%0d", tname, cyc_no);
    check({pfx, " htrans"}, htrans_o, e_tr);
    if (e_tr != ID) check({pfx, " haddr"}, haddr_o, e_addr);
    check({pfx, " wdata_ready"}, wdata_ready_o, e_wrdy);
    if (c_wd) check({pfx, " hwdata"}, hwdata_o, e_wd);
    check({pfx, " rdata_valid"}, rdata_valid_o, e_rv);
    if (e_rv) check({pfx, " rdata"}, rdata_o, e_rdata);
    check({pfx, " done"}, done_o, e_done);
    if (e_done) check({pfx, " err"}, err_o, e_err);
    tick();
    cyc_no++;
  endtask

  initial begin
    hrstn_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_i = '0; wdata_valid_i = 1'b0; hready_i = 1'b1; hresp_i = OK; hrdata_i = '0;
    tname = "reset"; cyc_no = 0;

    @(posedge hclk_i);
    #1;
    check("reset htrans", htrans_o, 0);
    check("reset haddr", haddr_o, 0);
    check("reset hwrite", hwrite_o, 0);
    check("reset hwdata", hwdata_o, 0);
    check("reset rdata", rdata_o, 0);
    check("reset rdata_valid", rdata_valid_o, 0);
    check("reset wdata_ready", wdata_ready_o, 0);
    check("reset done", done_o, 0);
    check("reset err", err_o, 0);
    check("reset cmd_ready", cmd_ready_o, 1);
    check("reset hsize", hsize_o, 3'b010);
    check("reset hburst", hburst_o, 3'b001);
    hrstn_i = 1'b1;
    tick();

    // Single write, zero wait states.
    tname = "wr1";
    issue_cmd(1'b1, 32'h1000, 10'd1);
    cyc(1, OK, 0, 1, 32'hDEADBEEF, NS, 32'h1000, 1, 0, 0,            0, 0, 0, 0);
    check("wr1 hwrite", hwrite_o, 1);
    cyc(1, OK, 0, 0, 0,            ID, 0,        0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(1, OK, 0, 0, 0,            ID, 0,        0, 1, 32'hDEADBEEF, 0, 0, 1, 0);
    cyc(1, OK, 0, 0, 0,            ID, 0,        0, 0, 0,            0, 0, 0, 0);

    // Read of 4 words with 2 wait states on the second data phase.
    tname = "rd_wait";
    issue_cmd(1'b0, 32'h2000, 10'd4);
    cyc(1, OK, G,            0, 0, NS, 32'h2000, 0, 0, 0, 0, 0,            0, 0);
    cyc(1, OK, 32'hCAFE0000, 0, 0, SQ, 32'h2004, 0, 0, 0, 0, 0,            0, 0);
    cyc(0, OK, G,            0, 0, SQ, 32'h2008, 0, 0, 0, 1, 32'hCAFE0000, 0, 0);
    cyc(0, OK, G,            0, 0, SQ, 32'h2008, 0, 0, 0, 0, 0,            0, 0);
    cyc(1, OK, 32'hCAFE0001, 0, 0, SQ, 32'h2008, 0, 0, 0, 0, 0,            0, 0);
    cyc(1, OK, 32'hCAFE0002, 0, 0, SQ, 32'h200C, 0, 0, 0, 1, 32'hCAFE0001, 0, 0);
    cyc(1, OK, 32'hCAFE0003, 0, 0, ID, 0,        0, 0, 0, 1, 32'hCAFE0002, 0, 0);
    cyc(1, OK, G,            0, 0, ID, 0,        0, 0, 0, 1, 32'hCAFE0003, 1, 0);

    // Write of 3 words with the source empty for 2 cycles after beat 1.
    tname = "wr_gap";
    issue_cmd(1'b1, 32'h4000, 10'd3);
    cyc(1, OK, 0, 1, 32'h11111111, NS, 32'h4000, 1, 0, 0,            0, 0, 0, 0);
    cyc(1, OK, 0, 0, 0,            BZ, 32'h4004, 0, 1, 32'h11111111, 0, 0, 0, 0);
    cyc(1, OK, 0, 0, 0,            BZ, 32'h4004, 0, 1, 32'h11111111, 0, 0, 0, 0);
    cyc(1, OK, 0, 1, 32'h22222222, SQ, 32'h4004, 1, 1, 32'h11111111, 0, 0, 0, 0);
    cyc(1, OK, 0, 1, 32'h33333333, SQ, 32'h4008, 1, 1, 32'h22222222, 0, 0, 0, 0);
    cyc(1, OK, 0, 0, 0,            ID, 0,        0, 1, 32'h33333333, 0, 0, 0, 0);
    cyc(1, OK, 0, 0, 0,            ID, 0,        0, 1, 32'h33333333, 0, 0, 1, 0);

    // Read crossing a 1 KB boundary restarts the burst with NONSEQ.
    tname = "kb_bound";
    issue_cmd(1'b0, 32'h03F8, 10'd4);
    cyc(1, OK, G,            0, 0, NS, 32'h03F8, 0, 0, 0, 0, 0,            0, 0);
    cyc(1, OK, 32'h5A5A0000, 0, 0, SQ, 32'h03FC, 0, 0, 0, 0, 0,            0, 0);
    cyc(1, OK, 32'h5A5A0001, 0, 0, NS, 32'h0400, 0, 0, 0, 1, 32'h5A5A0000, 0, 0);
    cyc(1, OK, 32'h5A5A0002, 0, 0, SQ, 32'h0404, 0, 0, 0, 1, 32'h5A5A0001, 0, 0);
    cyc(1, OK, 32'h5A5A0003, 0, 0, ID, 0,        0, 0, 0, 1, 32'h5A5A0002, 0, 0);
    cyc(1, OK, G,            0, 0, ID, 0,        0, 0, 0, 1, 32'h5A5A0003, 1, 0);

    // Write of 4 words with an ERROR response on the second data phase.
    tname = "bus_err";
    issue_cmd(1'b1, 32'h5000, 10'd4);
    cyc(1, OK, 0, 1, 32'hA0A0A0A0, NS, 32'h5000, 1, 0, 0,            0, 0, 0, 0);
    cyc(1, OK, 0, 1, 32'hB1B1B1B1, SQ, 32'h5004, 1, 1, 32'hA0A0A0A0, 0, 0, 0, 0);
    cyc(0, ER, 0, 1, 32'hC2C2C2C2, ID, 0,        0, 1, 32'hB1B1B1B1, 0, 0, 0, 0);
    cyc(1, ER, 0, 1, 32'hC2C2C2C2, ID, 0,        0, 1, 32'hB1B1B1B1, 0, 0, 0, 0);
    cyc(1, OK, 0, 1, 32'hC2C2C2C2, ID, 0,        0, 1, 32'hB1B1B1B1, 0, 0, 1, 1);
    cyc(1, OK, 0, 0, 0,            ID, 0,        0, 0, 0,            0, 0, 0, 0);

    // Zero-length command completes at once with no bus activity.
    tname = "len0";
    issue_cmd(1'b0, 32'h6000, 10'd0);
    cyc(1, OK, 0, 0, 0, ID, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, OK, 0, 0, 0, ID, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a write burst, then a normal read.
    tname = "rst_mid";
    issue_cmd(1'b1, 32'h7000, 10'd4);
    cyc(1, OK, 0, 1, 32'h0F0F0F0F, NS, 32'h7000, 1, 0, 0,            0, 0, 0, 0);
    cyc(1, OK, 0, 1, 32'hF0F0F0F0, SQ, 32'h7004, 1, 1, 32'h0F0F0F0F, 0, 0, 0, 0);
    hrstn_i = 1'b0;
    #1;
    check("rst_mid htrans", htrans_o, 0);
    check("rst_mid haddr", haddr_o, 0);
    check("rst_mid hwrite", hwrite_o, 0);
    check("rst_mid hwdata", hwdata_o, 0);
    check("rst_mid wdata_ready", wdata_ready_o, 0);
    check("rst_mid done", done_o, 0);
    check("rst_mid cmd_ready", cmd_ready_o, 1);
    #2;
    hrstn_i = 1'b1;
    wdata_valid_i = 1'b0;
    tick();
    tname = "after_rst";
    issue_cmd(1'b0, 32'h8000, 10'd1);
    cyc(1, OK, G,            0, 0, NS, 32'h8000, 0, 0, 0, 0, 0,            0, 0);
    cyc(1, OK, 32'h600DF00D, 0, 0, ID, 0,        0, 0, 0, 0, 0,            0, 0);
    cyc(1, OK, G,            0, 0, ID, 0,        0, 0, 0, 1, 32'h600DF00D, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
